mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store sequencer between the SPARC V8 datapath control unit and the word-organized `ram` block. It latches the effective address and store data into MAR/MDR and runs the multi-cycle RAM access. For loads it extracts and extends bytes and halfwords; for sub-word stores it performs a read-modify-write. Completion is signalled to the control unit with a one-cycle MFC (memory function complete) pulse.

## Interface
- `ADDR_W`, 9: RAM word-address width. The RAM word address is `addr[ADDR_W+1:2]`.
- `WAIT_CYCLES`, 2: extra cycles each RAM access holds `ram_en` high. Legal range is 0–7.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request strobe, sampled only in IDLE.
- `rw` in 1: 1 = load, 0 = store.
- `size` in 2: 00 byte, 01 halfword, 10 word, 11 reserved.
- `sign_ext` in 1: for loads, 1 = sign-extend, 0 = zero-extend.
- `addr` in 32: byte effective address.
- `wdata` in 32: store data, right-justified for sub-word stores.
- `busy` out 1: high from the cycle after `start` is accepted through the MFC cycle.
- `mfc` out 1: one-cycle completion pulse.
- `align_err` out 1: one-cycle pulse, coincident with `mfc`, when the request is rejected.
- `rdata` out 32: load result. Holds its value until the next completed load.
- `ram_en` out 1: RAM enable.
- `ram_we` out 1: RAM write strobe, qualified by `ram_en`.
- `ram_addr` out ADDR_W: RAM word address.
- `ram_wdata` out 32: RAM write word (MDR out).
- `ram_rdata` in 32: RAM read word (MDR in).

## Operation
- FSM states: IDLE, ACC_RD, ACC_WR, RMW_RD, RMW_WR, DONE.
- IDLE, `start`=1: latch `addr`, `wdata`, `rw`, `size` and `sign_ext` into MAR/MDR/control registers, then take the first matching transition:
  - misaligned request → DONE with error flag;
  - load → ACC_RD;
  - word store → ACC_WR;
  - byte or halfword store → RMW_RD.
- Misaligned request:
  - halfword with `addr[0]`=1;
  - word with `addr[1:0]`≠0;
  - any request with `size`=11.
- Each ACC_* / RMW_* state lasts exactly WAIT_CYCLES+1 cycles, driven by a 3-bit wait counter that resets on state entry. `ram_en`=1 throughout; `ram_we`=1 only in ACC_WR and RMW_WR.
- `ram_rdata` is sampled on the last cycle of ACC_RD and RMW_RD.
- Byte lanes are big-endian:
  - byte offset 0 → bits [31:24], offset 3 → bits [7:0];
  - halfword offset 0 → [31:16], offset 2 → [15:0].
- Load: the selected lane is right-justified, then sign- or zero-extended per `sign_ext`, and written to `rdata` on exit from ACC_RD. ACC_RD → DONE.
- Word store: `ram_wdata` = MDR. ACC_WR → DONE.
- Sub-word store: RMW_RD captures the old word. RMW_WR writes the old word with the addressed lane replaced by `wdata[7:0]` or `wdata[15:0]`. RMW_WR → DONE.
- DONE: `mfc`=1 for one cycle; `align_err`=1 if flagged. DONE → IDLE.
- `start` while `busy` is ignored and not queued.
- Inputs other than `start` are don't-care after acceptance.

## Timing
- Reset values:
  - state IDLE;
  - `busy`, `mfc`, `align_err`, `ram_en`, `ram_we` all 0;
  - `rdata`, `ram_addr`, `ram_wdata`, MAR, MDR all 0.
- Let W = WAIT_CYCLES and let edge 0 be the edge that accepts `start`.
- Load or word store: `ram_en` is high during cycles 1..W+1. `mfc` is high in cycle W+2. `rdata` is valid from cycle W+2.
- Sub-word store: read phase in cycles 1..W+1, write phase in cycles W+2..2W+2. `mfc` is high in cycle 2W+3.
- Misaligned request: `mfc` and `align_err` are high in cycle 1. No RAM access occurs and `rdata` is unchanged.
- A new `start` is accepted in the cycle after DONE at the earliest. Back-to-back request spacing is W+3 cycles.
- `rst_n` low mid-access: `ram_en` and `ram_we` drop immediately (asynchronous), state goes to IDLE, and no `mfc` is issued. A partially completed RMW leaves RAM unwritten.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `MAU_MISALIGN_TRAP_EN` defined: misalignment detection as described above. `align_err` is active.
- `MAU_MISALIGN_TRAP_EN` not defined:
  - low address bits are forced to alignment (`addr[0]` cleared for halfword, `addr[1:0]` cleared for word) and the access proceeds normally;
  - `size`=11 is treated as word;
  - `align_err` is tied to 0.

## Test plan
- Word store then load (W=2): store 0xDEADBEEF to 0x10, then load word from 0x10. `ram_we` is high for 3 cycles. Each `mfc` is 4 cycles after `start`. `rdata`=0xDEADBEEF.
- Signed byte load: RAM word 0x80 holds 0x12F45678. Load byte from 0x81 with `sign_ext`=1 → 0xFFFFFFF4. With `sign_ext`=0 → 0x000000F4.
- Halfword RMW: RAM word 0x20 holds 0x11223344. Store halfword 0xABCD to 0x22. Read phase then write phase are observed, `mfc` is 7 cycles after `start`, and the word becomes 0x1122ABCD.
- Misalignment, with the macro defined: load word from 0x06 → `mfc`=`align_err`=1 in cycle 1, `ram_en` never asserted, `rdata` unchanged. Without the macro, the same request reads word 0x04.
- `start` pulsed while `busy` → ignored; exactly one `mfc` is produced.
- `rst_n` asserted in cycle 2 of a byte-store RMW → outputs return to reset values immediately and the RAM word is unchanged.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response and RAM-side bus of the load/store unit.
// master = control unit + RAM; slave = mem_access_unit.
interface mem_access_unit_if #(
  parameter int ADDR_W = 9
);
  logic              start;
  logic              rw;
  logic [1:0]        size;
  logic              sign_ext;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              mfc;
  logic              align_err;
  logic [31:0]       rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport master (
    output start, rw, size, sign_ext,
    output addr, wdata, ram_rdata,
    input  busy, mfc, align_err, rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  start, rw, size, sign_ext,
    input  addr, wdata, ram_rdata,
    output busy, mfc, align_err, rdata,
    output ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MAR/MDR load/store sequencer with sub-word RMW and MFC pulse.
// Ports: clk, rst_n (async low), bus (mem_access_unit_if.slave). Macro: MAU_MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC_RD,
    S_ACC_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_DONE
  } state_t;

  localparam logic [2:0] LP_LAST = 3'(WAIT_CYCLES);

  state_t      r_state;
  state_t      w_nxt;
  logic [2:0]  r_cnt;
  logic [31:0] r_mar;
  logic [31:0] r_mdr;
  logic [31:0] r_rdata;
  logic [1:0]  r_size;
  logic        r_sext;
  logic        r_busy;
  logic        r_mfc;
  logic        r_aerr;
  logic        r_ram_en;
  logic        r_ram_we;

  logic        w_acc;
  logic        w_last;
  logic        w_mis;
  logic [1:0]  w_size_n;
  logic [31:0] w_addr_n;
  logic [4:0]  w_bsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;
  logic        w_unused;

  assign w_acc  = (r_state == S_IDLE) && bus.start;
  assign w_last = (r_cnt == LP_LAST);

  always_comb begin
    w_size_n = bus.size;
    w_addr_n = bus.addr;
    w_mis    = 1'b0;
`ifdef MAU_MISALIGN_TRAP_EN
    unique case (bus.size)
      2'b01:   w_mis = bus.addr[0];
      2'b10:   w_mis = |bus.addr[1:0];
      2'b11:   w_mis = 1'b1;
      default: w_mis = 1'b0;
    endcase
`else
    if (bus.size == 2'b11) w_size_n = 2'b10;
    if (w_size_n == 2'b01) w_addr_n[0] = 1'b0;
    if (w_size_n == 2'b10) w_addr_n[1:0] = 2'b00;
`endif
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          unique case (1'b1)
            w_mis:
              w_nxt = S_DONE;
            !w_mis && bus.rw:
              w_nxt = S_ACC_RD;
            !w_mis && !bus.rw && (w_size_n == 2'b10):
              w_nxt = S_ACC_WR;
            default:
              w_nxt = S_RMW_RD;
          endcase
        end
      end
      S_ACC_RD: if (w_last) w_nxt = S_DONE;
      S_ACC_WR: if (w_last) w_nxt = S_DONE;
      S_RMW_RD: if (w_last) w_nxt = S_RMW_WR;
      S_RMW_WR: if (w_last) w_nxt = S_DONE;
      S_DONE:   w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  // Big-endian lanes: byte offset 0 lives in bits [31:24].
  always_comb begin
    w_bsh  = {~r_mar[1:0], 3'b000};
    w_byte = bus.ram_rdata[w_bsh +: 8];
    w_half = r_mar[1] ? bus.ram_rdata[15:0]
                      : bus.ram_rdata[31:16];
    unique case (r_size)
      2'b00:
        w_load = {{24{r_sext & w_byte[7]}}, w_byte};
      2'b01:
        w_load = {{16{r_sext & w_half[15]}}, w_half};
      default:
        w_load = bus.ram_rdata;
    endcase
    w_merge = bus.ram_rdata;
    if (r_size == 2'b00)
      w_merge[w_bsh +: 8] = r_mdr[7:0];
    else if (r_mar[1])
      w_merge[15:0] = r_mdr[15:0];
    else
      w_merge[31:16] = r_mdr[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_nxt;
      if ((w_nxt != r_state) || (r_state == S_IDLE))
        r_cnt <= 3'd0;
      else
        r_cnt <= r_cnt + 3'd1;
    end
  end

  // Outputs are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mar    <= '0;
      r_mdr    <= '0;
      r_rdata  <= '0;
      r_size   <= 2'b00;
      r_sext   <= 1'b0;
      r_busy   <= 1'b0;
      r_mfc    <= 1'b0;
      r_aerr   <= 1'b0;
      r_ram_en <= 1'b0;
      r_ram_we <= 1'b0;
    end else begin
      if (w_acc) begin
        r_mar  <= w_addr_n;
        r_mdr  <= bus.wdata;
        r_size <= w_size_n;
        r_sext <= bus.sign_ext;
      end
      // MDR takes the merged word so RMW_WR writes it unchanged.
      if ((r_state == S_RMW_RD) && w_last)
        r_mdr <= w_merge;
      if ((r_state == S_ACC_RD) && w_last)
        r_rdata <= w_load;
      r_busy   <= (w_nxt != S_IDLE);
      r_mfc    <= (w_nxt == S_DONE);
      r_aerr   <= w_acc && w_mis;
      r_ram_en <= (w_nxt == S_ACC_RD) || (w_nxt == S_ACC_WR)
               || (w_nxt == S_RMW_RD) || (w_nxt == S_RMW_WR);
      r_ram_we <= (w_nxt == S_ACC_WR) || (w_nxt == S_RMW_WR);
    end
  end

  assign bus.busy      = r_busy;
  assign bus.mfc       = r_mfc;
  assign bus.rdata     = r_rdata;
  assign bus.ram_en    = r_ram_en;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_addr  = r_mar[ADDR_W+1:2];
  assign bus.ram_wdata = r_mdr;

`ifdef MAU_MISALIGN_TRAP_EN
  assign bus.align_err = r_aerr;
  assign w_unused      = ^{r_mar[31:ADDR_W+2]};
`else
  assign bus.align_err = 1'b0;
  assign w_unused      = ^{r_mar[31:ADDR_W+2], r_aerr};
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench with RAM, spec-level model and per-cycle compare.
// Also pins the model with hand-computed literal results.
module tb_mem_access_unit;
  localparam int AW = 9;
  localparam int W  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(AW)) bus ();

  mem_access_unit #(
    .ADDR_W(AW),
    .WAIT_CYCLES(W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  logic [31:0] mem  [0:511];
  logic [31:0] gold [0:511];
  logic        pl_en = 1'b0;
  logic [8:0]  pl_a  = '0;
  logic [31:0] pl_d  = '0;

  always @(posedge clk) begin
    if (pl_en)
      mem[pl_a] <= pl_d;
    else if (bus.ram_en && bus.ram_we)
      mem[bus.ram_addr] <= bus.ram_wdata;
  end
  assign bus.ram_rdata = mem[bus.ram_addr];

  function automatic int shamt(int sz, logic [1:0] off);
    if (sz == 0) return (3 - int'(off)) * 8;
    if (sz == 1) return (2 - int'(off)) * 8;
    return 0;
  endfunction

  function automatic logic [31:0] lmask(int sz);
    if (sz == 0) return 32'h0000_00FF;
    if (sz == 1) return 32'h0000_FFFF;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] lane_get(logic [31:0] wd, int sz,
                                           logic [1:0] off, bit sx);
    logic [31:0] mk, v;
    mk = lmask(sz);
    v  = (wd >> shamt(sz, off)) & mk;
    if (sx && sz < 2 && ((v & ((mk >> 1) + 1)) != 0))
      v = v | ~mk;
    return v;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd,
                                        int sz, logic [1:0] off);
    logic [31:0] mk;
    mk = lmask(sz);
    return (old & ~(mk << shamt(sz, off)))
         | ((wd & mk) << shamt(sz, off));
  endfunction

  bit          m_act = 0;
  int          m_k = 0, m_end = 0, m_sz = 0;
  bit          m_err = 0, m_ld = 0, m_sub = 0, m_sx = 0;
  logic [31:0] m_a = '0;
  logic [8:0]  m_idx = '0;
  logic [1:0]  m_off = '0;
  logic [31:0] m_wword = '0;
  logic [31:0] m_rdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act   = 0;
      m_k     = 0;
      m_rdata = '0;
    end else begin
      if (pl_en) gold[pl_a] = pl_d;
      if (m_act) begin
        if (m_k == m_end) begin
          m_act = 0;
          m_k   = 0;
        end else begin
          m_k++;
          if (m_k == m_end && !m_err) begin
            if (m_ld) m_rdata = lane_get(gold[m_idx], m_sz, m_off, m_sx);
            else      gold[m_idx] = m_wword;
          end
        end
      end else if (bus.start) begin
        m_sz  = int'(bus.size);
        m_a   = bus.addr;
        m_err = 0;
`ifdef MAU_MISALIGN_TRAP_EN
        if (m_sz == 3 || (m_sz == 1 && m_a % 2 != 0)
            || (m_sz == 2 && m_a % 4 != 0))
          m_err = 1;
`else
        if (m_sz == 3) m_sz = 2;
        if (m_sz == 1) m_a = m_a - m_a % 2;
        if (m_sz == 2) m_a = m_a - m_a % 4;
`endif
        m_idx = m_a[10:2];
        m_off = m_a[1:0];
        m_ld  = bus.rw;
        m_sx  = bus.sign_ext;
        m_sub = !bus.rw && m_sz < 2;
        if (!m_ld)
          m_wword = m_sub ? merge(gold[m_idx], bus.wdata, m_sz, m_off)
                          : bus.wdata;
        m_end = m_err ? 1 : (m_sub ? 2 * W + 3 : W + 2);
        m_act = 1;
        m_k   = 1;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int n_mfc = 0;
  int n_we  = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cmp_loop();
    bit en_e, we_e, mfc_e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      en_e  = m_act && !m_err
           && m_k <= (m_sub ? 2 * W + 2 : W + 1);
      we_e  = m_act && !m_err && !m_ld
           && (m_sub ? (m_k >= W + 2 && m_k <= 2 * W + 2)
                     : (m_k <= W + 1));
      mfc_e = m_act && m_k == m_end;
      check("busy", 32'(bus.busy), 32'(m_act));
      check("mfc", 32'(bus.mfc), 32'(mfc_e));
      check("align_err", 32'(bus.align_err), 32'(mfc_e && m_err));
      check("ram_en", 32'(bus.ram_en), 32'(en_e));
      check("ram_we", 32'(bus.ram_we), 32'(we_e));
      check("rdata", bus.rdata, m_rdata);
      if (en_e) check("ram_addr", 32'(bus.ram_addr), 32'(m_idx));
      if (we_e) check("ram_wdata", bus.ram_wdata, m_wword);
      if (bus.mfc) n_mfc++;
      if (bus.ram_en && bus.ram_we) n_we++;
    end
  endtask

  task automatic preload(logic [8:0] a, logic [31:0] d);
    pl_a  = a;
    pl_d  = d;
    pl_en = 1'b1;
    @(posedge clk);
    #2 pl_en = 1'b0;
  endtask

  task automatic req(bit rw, logic [1:0] sz, bit sx,
                     logic [31:0] a, logic [31:0] wd, output int lat);
    bus.start    = 1'b1;
    bus.rw       = rw;
    bus.size     = sz;
    bus.sign_ext = sx;
    bus.addr     = a;
    bus.wdata    = wd;
    @(posedge clk);
    #2 bus.start = 1'b0;
    lat = -1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (bus.mfc) begin
        lat = j;
        break;
      end
    end
    if (lat < 0) check("mfc_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    int lat, c0;
    bus.start    = 1'b0;
    bus.rw       = 1'b0;
    bus.size     = 2'b00;
    bus.sign_ext = 1'b0;
    bus.addr     = '0;
    bus.wdata    = '0;
    fork
      cmp_loop();
    join_none
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
    check("rst_ram_wdata", bus.ram_wdata, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);

    // word store then word load
    c0 = n_we;
    req(1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat);
    check("wst_lat", 32'(lat), 32'd4);
    check("wst_we_cycles", 32'(n_we - c0), 32'd3);
    req(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, lat);
    check("wld_lat", 32'(lat), 32'd4);
    check("wld_rdata", bus.rdata, 32'hDEADBEEF);

    // byte/halfword loads
    preload(9'd32, 32'h12F45678);
    req(1'b1, 2'b00, 1'b1, 32'h81, 32'h0, lat);
    check("lb_sx", bus.rdata, 32'hFFFFFFF4);
    req(1'b1, 2'b00, 1'b0, 32'h81, 32'h0, lat);
    check("lb_zx", bus.rdata, 32'h000000F4);
    req(1'b1, 2'b00, 1'b1, 32'h83, 32'h0, lat);
    check("lb_off3", bus.rdata, 32'h00000078);
    req(1'b1, 2'b01, 1'b1, 32'h80, 32'h0, lat);
    check("lh_off0", bus.rdata, 32'h000012F4);
    req(1'b1, 2'b01, 1'b1, 32'h82, 32'h0, lat);
    check("lh_off2", bus.rdata, 32'h00005678);

    // sub-word RMW stores
    preload(9'd8, 32'h11223344);
    req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0000ABCD, lat);
    check("sh_lat", 32'(lat), 32'd7);
    req(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, lat);
    check("sh_word", bus.rdata, 32'h1122ABCD);
    req(1'b0, 2'b00, 1'b0, 32'h20, 32'hFFFFFF55, lat);
    req(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, lat);
    check("sb_word", bus.rdata, 32'h5522ABCD);

    // misaligned word load
    preload(9'd1, 32'h0BADF00D);
    req(1'b1, 2'b10, 1'b0, 32'h06, 32'h0, lat);
`ifdef MAU_MISALIGN_TRAP_EN
    check("mis_lat", 32'(lat), 32'd1);
    check("mis_rdata", bus.rdata, 32'h5522ABCD);
`else
    check("mis_lat", 32'(lat), 32'd4);
    check("mis_rdata", bus.rdata, 32'h0BADF00D);
`endif

    // start while busy is ignored
    c0 = n_mfc;
    bus.start = 1'b1;
    bus.rw    = 1'b1;
    bus.size  = 2'b10;
    bus.addr  = 32'h10;
    @(posedge clk);
    #2 bus.start = 1'b0;
    @(posedge clk);
    #2 bus.start = 1'b1;
    @(posedge clk);
    #2 bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    check("busy_start_mfcs", 32'(n_mfc - c0), 32'd1);
    check("busy_start_rdata", bus.rdata, 32'hDEADBEEF);

    // reset in cycle 2 of a byte-store RMW
    preload(9'd16, 32'hCAFEBABE);
    bus.start = 1'b1;
    bus.rw    = 1'b0;
    bus.size  = 2'b00;
    bus.addr  = 32'h41;
    bus.wdata = 32'h99;
    @(posedge clk);
    #2 bus.start = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_en", 32'(bus.ram_en), 32'h0);
    check("arst_we", 32'(bus.ram_we), 32'h0);
    check("arst_busy", 32'(bus.busy), 32'h0);
    check("arst_rdata", bus.rdata, 32'h0);
    check("arst_ram_addr", 32'(bus.ram_addr), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;
    req(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, lat);
    check("arst_ram_kept", bus.rdata, 32'hCAFEBABE);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
